// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Two-flop synchroniser, mid-bit sampling on the oversampling tick, LSB-first
// data, one stop bit. Registered single-cycle strobes for valid/framing/parity.
// Optional even parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic                 sysclk_in,
    input  logic                 rst_in,
    input  logic                 divpulse_in,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    output logic                 rx_busy_out,
    output logic                 rx_frame_err_out,
    output logic                 rx_parity_err_out
);
    localparam int TICK_W = $clog2(OVERSAMPLING);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLING / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                state_reg;
    logic [1:0]            sync_reg;
    logic [TICK_W-1:0]     tick_cnt_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  data_reg;
    logic                  valid_reg;
    logic                  frame_err_reg;
    logic                  rxs;

    // Synchronise the asynchronous line; reset to idle-high so no false start
    always_ff @(posedge sysclk_in) begin
        if (rst_in) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_serial_in};
        end
    end

    assign rxs = sync_reg[1];

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg;
    logic parity_err_reg;
`endif

    // Receive state machine with registered data and strobes
    always_ff @(posedge sysclk_in) begin
        if (rst_in) begin
            state_reg      <= S_IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (divpulse_in && !rxs) begin
                        state_reg    <= S_START;
                        tick_cnt_reg <= '0;
                    end
                end
                S_START: begin
                    if (divpulse_in) begin
                        if (tick_cnt_reg == TICK_MID) begin
                            // Line still low at mid start bit: genuine start
                            if (!rxs) begin
                                state_reg    <= S_DATA;
                                tick_cnt_reg <= '0;
                                bit_cnt_reg  <= '0;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (divpulse_in) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            shift_reg    <= {rxs, shift_reg[DATA_BITS-1:1]};
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= bit_cnt_reg + BIT_ONE;
                            if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= S_PARITY;
`else
                                state_reg <= S_STOP;
`endif
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (divpulse_in) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            // Even parity: received bit must equal XOR of data
                            parity_bad_reg <= rxs ^ (^shift_reg);
                            tick_cnt_reg   <= '0;
                            state_reg      <= S_STOP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (divpulse_in) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            data_reg     <= shift_reg;
                            tick_cnt_reg <= '0;
                            if (rxs) begin
                                valid_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_reg <= parity_bad_reg;
`endif
                                state_reg <= S_IDLE;
                            end else begin
                                // Low stop bit: flag it and wait out the break
                                frame_err_reg <= 1'b1;
                                state_reg     <= S_BREAK;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data_out      = data_reg;
    assign rx_valid_out     = valid_reg;
    assign rx_frame_err_out = frame_err_reg;
    assign rx_busy_out      = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err_out = parity_err_reg;
`else
    assign rx_parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// The bench plays the transmitter, driving rx_serial_in bit by bit on a tick
// grid of DIV clocks per oversampling tick. Honours UART_RX_PARITY_EN.
module tb_uart_rx;
    localparam int OS      = 8;
    localparam int DB      = 8;
    localparam int DIV     = 5;
    localparam int BIT_CYC = OS * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic          sysclk_in    = 1'b0;
    logic          rst_in       = 1'b1;
    logic          divpulse_in  = 1'b0;
    logic          rx_serial_in = 1'b1;
    logic [DB-1:0] rx_data_out;
    logic          rx_valid_out;
    logic          rx_busy_out;
    logic          rx_frame_err_out;
    logic          rx_parity_err_out;

    int n_checks       = 0;
    int n_errors       = 0;
    int cyc            = 0;
    int div_cnt        = 0;
    int valid_cnt      = 0;
    int ferr_cnt       = 0;
    int perr_cnt       = 0;
    int perr_valid_cnt = 0;
    int busy_cyc       = 0;
    logic [DB-1:0] ferr_data = '0;
    logic [DB-1:0] data_q[$];
    int            stamp_q[$];

    logic [7:0] loop_vec [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'hFE, 8'h7F, 8'h3C, 8'hC3, 8'hA5, 8'h5A, 8'h99, 8'h66};
    logic [7:0] b2b_vec [3]   = '{8'h00, 8'hFF, 8'h55};

    uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
        .sysclk_in         (sysclk_in),
        .rst_in            (rst_in),
        .divpulse_in       (divpulse_in),
        .rx_serial_in      (rx_serial_in),
        .rx_data_out       (rx_data_out),
        .rx_valid_out      (rx_valid_out),
        .rx_busy_out       (rx_busy_out),
        .rx_frame_err_out  (rx_frame_err_out),
        .rx_parity_err_out (rx_parity_err_out)
    );

    always #5 sysclk_in = ~sysclk_in;

    // Oversampling tick: one cycle in every DIV, updated on the falling edge
    always @(negedge sysclk_in) begin
        div_cnt     = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
        divpulse_in = (div_cnt == 0);
    end

    // Output monitor, sampled on the falling edge
    always @(negedge sysclk_in) begin
        cyc++;
        if (rx_valid_out) begin
            data_q.push_back(rx_data_out);
            stamp_q.push_back(cyc);
            valid_cnt++;
            if (rx_parity_err_out) perr_valid_cnt++;
        end
        if (rx_frame_err_out) begin
            ferr_cnt++;
            ferr_data = rx_data_out;
        end
        if (rx_parity_err_out) perr_cnt++;
        if (rx_busy_out) busy_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic b, input int cycles);
        rx_serial_in = b;
        repeat (cycles) @(negedge sysclk_in);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bits(1'b0, BIT_CYC);
        for (int i = 0; i < DB; i++) send_bits(d[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
        send_bits(par, BIT_CYC);
`endif
        send_bits(stop, BIT_CYC);
        $display("frame 0x%02h parity %0d stop %0d sent at cycle %0d", d, par, stop, cyc);
    endtask

    initial begin
        int base_v;
        int base_f;
        int base_p;
        int base_pv;
        int base_q;

        repeat (5) @(negedge sysclk_in);
        rst_in = 1'b0;
        @(negedge sysclk_in);

        // Reset state
        check("rst_data", rx_data_out, 0);
        check("rst_valid", rx_valid_out, 0);
        check("rst_busy", rx_busy_out, 0);
        check("rst_ferr", rx_frame_err_out, 0);
        check("rst_perr", rx_parity_err_out, 0);
        send_bits(1'b1, 2 * BIT_CYC);

        // Loopback of 16 bytes with one idle bit between frames
        base_v = valid_cnt; base_f = ferr_cnt; base_q = data_q.size(); base_p = perr_cnt;
        for (int i = 0; i < 16; i++) begin
            send_frame(loop_vec[i], ^loop_vec[i], 1'b1);
            send_bits(1'b1, BIT_CYC);
        end
        check("loop_count", valid_cnt - base_v, 16);
        check("loop_ferr", ferr_cnt - base_f, 0);
        check("loop_perr", perr_cnt - base_p, 0);
        if (data_q.size() >= base_q + 16) begin
            for (int i = 0; i < 16; i++)
                check($sformatf("loop_data[%0d]", i), data_q[base_q + i], loop_vec[i]);
        end

        // Glitch: 3 ticks low is rejected as a false start
        base_v = valid_cnt; base_f = ferr_cnt;
        busy_cyc = 0;
        send_bits(1'b0, 3 * DIV);
        send_bits(1'b1, 2 * BIT_CYC);
        $display("glitch sent, busy for %0d cycles", busy_cyc);
        check("glitch_valid", valid_cnt - base_v, 0);
        check("glitch_ferr", ferr_cnt - base_f, 0);
        check("glitch_busy_seen", busy_cyc > 0, 1);
        check("glitch_busy_max", busy_cyc <= 4 * DIV, 1);
        check("glitch_idle", rx_busy_out, 0);

        // Framing error, then line held low for two bit times
        base_v = valid_cnt; base_f = ferr_cnt;
        send_frame(8'hA5, ^8'hA5, 1'b0);
        send_bits(1'b0, 2 * BIT_CYC);
        check("break_busy", rx_busy_out, 1);
        check("break_ferr_once", ferr_cnt - base_f, 1);
        send_bits(1'b1, 2 * BIT_CYC);
        check("ferr_count", ferr_cnt - base_f, 1);
        check("ferr_data", ferr_data, 8'hA5);
        check("ferr_data_out", rx_data_out, 8'hA5);
        check("ferr_no_valid", valid_cnt - base_v, 0);
        check("ferr_idle", rx_busy_out, 0);

        // Reset during data bit 4 of 0x3C
        base_v = valid_cnt; base_f = ferr_cnt;
        send_bits(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) send_bits(1'(8'h3C >> i), BIT_CYC);
        send_bits(1'b1, BIT_CYC / 2);
        check("pre_rst_busy", rx_busy_out, 1);
        rst_in = 1'b1;
        @(negedge sysclk_in);
        rst_in = 1'b0;
        $display("reset pulsed mid-frame at cycle %0d", cyc);
        check("mid_rst_data", rx_data_out, 0);
        check("mid_rst_busy", rx_busy_out, 0);
        check("mid_rst_valid", rx_valid_out, 0);
        check("mid_rst_ferr", rx_frame_err_out, 0);
        check("mid_rst_perr", rx_parity_err_out, 0);
        send_bits(1'b1, 2 * BIT_CYC);
        check("mid_rst_no_valid", valid_cnt - base_v, 0);
        check("mid_rst_no_ferr", ferr_cnt - base_f, 0);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        send_bits(1'b1, BIT_CYC);
        check("after_rst_count", valid_cnt - base_v, 1);
        check("after_rst_data", rx_data_out, 8'h5A);

        // Back-to-back frames with no idle gap
        base_v = valid_cnt; base_q = data_q.size();
        for (int i = 0; i < 3; i++) send_frame(b2b_vec[i], ^b2b_vec[i], 1'b1);
        send_bits(1'b1, BIT_CYC);
        check("b2b_count", valid_cnt - base_v, 3);
        if (data_q.size() >= base_q + 3) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b_data[%0d]", i), data_q[base_q + i], b2b_vec[i]);
            check("b2b_gap0", stamp_q[base_q + 1] - stamp_q[base_q], FRAME_BITS * BIT_CYC);
            check("b2b_gap1", stamp_q[base_q + 2] - stamp_q[base_q + 1], FRAME_BITS * BIT_CYC);
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has odd weight, so a correct parity bit is 1
        base_v = valid_cnt; base_p = perr_cnt; base_pv = perr_valid_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        send_bits(1'b1, BIT_CYC);
        check("par_ok_valid", valid_cnt - base_v, 1);
        check("par_ok_perr", perr_cnt - base_p, 0);
        check("par_ok_data", rx_data_out, 8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        send_bits(1'b1, BIT_CYC);
        check("par_bad_valid", valid_cnt - base_v, 2);
        check("par_bad_perr", perr_cnt - base_p, 1);
        check("par_bad_same_cycle", perr_valid_cnt - base_pv, 1);
        check("par_bad_data", rx_data_out, 8'h07);
`else
        check("no_parity_err_ever", perr_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
